regs_wport_arbiter: RTL and testbench

- Shares the register file's single write port (wen/waddr/wdata) among N_REQ write-back sources: 0=EX, 1=LSU load, 2=DIV.
- Arbitration is round-robin with a valid/ready handshake, followed by a registered output stage feeding the register file write port.
- Keeps a busy scoreboard of destination registers reserved by long-latency ops, so ID can stall on RAW/WAW hazards.
- Sits between EX/LSU/DIV and the register file; busy_o goes to ID.

---
 rtl/regs_wport_arbiter_pkg.sv | 23 ++
 rtl/regs_wport_arbiter_rr_arbiter.sv | 63 ++++++
 rtl/regs_wport_arbiter.sv | 107 ++++++++++
 tb/tb_regs_wport_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regs_wport_arbiter_pkg.sv
// rtl/regs_wport_arbiter_pkg.sv - shared constants and helpers for the write-port arbiter
package regs_wport_arbiter_pkg;

    // Default register file geometry
    localparam int DEF_AW = 5;
    localparam int DEF_DW = 32;

    // Architectural zero register; writes to it are consumed but discarded
    localparam int ZERO_REG = 0;

    // Write-back source indices
    typedef enum int {
        REQ_EX  = 0,
        REQ_LSU = 1,
        REQ_DIV = 2
    } req_id_e;

    // Next round-robin start position after a grant to k
    function automatic int rr_next(input int k, input int n);
        return (k + 1 >= n) ? 0 : k + 1;
    endfunction

endpackage

// File: rtl/regs_wport_arbiter_rr_arbiter.sv
// rtl/regs_wport_arbiter_rr_arbiter.sv - N-way round-robin grant with optional EX priority override
module rr_arbiter
    import regs_wport_arbiter_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  valid,
    input  logic          prio_en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_any
);

    localparam int PRIO_IDX = int'(REQ_EX);

    logic [IW-1:0] ptr;
    logic [N-1:0]  cand;
    int            idx;
    logic          prio_hit;

    // Pick the first valid requester at or after ptr, unless the priority source claims the port
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = valid;
        idx       = 0;
        prio_hit  = prio_en && valid[PRIO_IDX];
        if (prio_hit) begin
            grant[PRIO_IDX] = 1'b1;
            grant_idx       = IW'(PRIO_IDX);
            grant_any       = 1'b1;
        end else begin
            if (prio_en) begin
                cand[PRIO_IDX] = 1'b0;
            end
            for (int off = 0; off < N; off++) begin
                idx = int'(ptr) + off;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (!grant_any && cand[IW'(idx)]) begin
                    grant[IW'(idx)] = 1'b1;
                    grant_idx       = IW'(idx);
                    grant_any       = 1'b1;
                end
            end
        end
    end

    // Advance the pointer past the winner; priority grants leave it untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (grant_any && !prio_hit) begin
            ptr <= IW'(rr_next(int'(grant_idx), N));
        end
    end

endmodule

// File: rtl/regs_wport_arbiter.sv
// rtl/regs_wport_arbiter.sv - register file write-port arbiter with busy scoreboard (option: WPORT_EX_PRIO_EN)
module regs_wport_arbiter
    import regs_wport_arbiter_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid_i,
    input  logic [N_REQ*AW-1:0] req_waddr_i,
    input  logic [N_REQ*DW-1:0] req_wdata_i,
    output logic [N_REQ-1:0]    req_ready_o,
    input  logic                alloc_valid_i,
    input  logic [AW-1:0]       alloc_addr_i,
    output logic                reg_wen_o,
    output logic [AW-1:0]       reg_waddr_o,
    output logic [DW-1:0]       reg_wdata_o,
    output logic [(1<<AW)-1:0]  busy_o
);

    localparam int NR = 1 << AW;
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

`ifdef WPORT_EX_PRIO_EN
    localparam logic PRIO_EN = 1'b1;
`else
    localparam logic PRIO_EN = 1'b0;
`endif

    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    grant_idx;
    logic             grant_any;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_data;
    logic [NR-1:0]    busy_q;
    logic [NR-1:0]    busy_next;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr (
        .clk       (clk),
        .rst_n     (rst),
        .valid     (req_valid_i),
        .prio_en   (PRIO_EN),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // No handshake can complete while reset is held
    assign req_ready_o = rst ? grant : '0;

    // Steer the winner's address and data (grant is one-hot)
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_waddr_i[i*AW +: AW];
                sel_data = req_wdata_i[i*DW +: DW];
            end
        end
    end

    // Registered write port; x0 transfers are consumed without raising the enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_wen_o   <= 1'b0;
            reg_waddr_o <= '0;
            reg_wdata_o <= '0;
        end else if (grant_any) begin
            reg_wen_o   <= (sel_addr != AW'(ZERO_REG));
            reg_waddr_o <= sel_addr;
            reg_wdata_o <= sel_data;
        end else begin
            reg_wen_o   <= 1'b0;
        end
    end

    // Scoreboard next state: allocation beats retirement of the same register
    always_comb begin
        busy_next    = busy_q;
        busy_next[0] = 1'b0;
        for (int r = 1; r < NR; r++) begin
            if (alloc_valid_i && (alloc_addr_i == AW'(r))) begin
                busy_next[r] = 1'b1;
            end else if (grant_any && (sel_addr == AW'(r))) begin
                busy_next[r] = 1'b0;
            end
        end
    end

    // Scoreboard state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: tb/tb_regs_wport_arbiter.sv
// tb/tb_regs_wport_arbiter.sv - self-checking bench for regs_wport_arbiter (option: WPORT_EX_PRIO_EN)
module tb_regs_wport_arbiter;
    import regs_wport_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 1 << AW;

`ifdef WPORT_EX_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      req_valid_i = '0;
    logic [N*AW-1:0]   req_waddr_i = '0;
    logic [N*DW-1:0]   req_wdata_i = '0;
    logic [N-1:0]      req_ready_o;
    logic              alloc_valid_i = 1'b0;
    logic [AW-1:0]     alloc_addr_i = '0;
    logic              reg_wen_o;
    logic [AW-1:0]     reg_waddr_o;
    logic [DW-1:0]     reg_wdata_o;
    logic [NR-1:0]     busy_o;

    regs_wport_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid_i),
        .req_waddr_i   (req_waddr_i),
        .req_wdata_i   (req_wdata_i),
        .req_ready_o   (req_ready_o),
        .alloc_valid_i (alloc_valid_i),
        .alloc_addr_i  (alloc_addr_i),
        .reg_wen_o     (reg_wen_o),
        .reg_waddr_o   (reg_waddr_o),
        .reg_wdata_o   (reg_wdata_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Stimulus per requester
    logic [N-1:0]  v_valid = '0;
    logic [AW-1:0] v_addr [N];
    logic [DW-1:0] v_data [N];
    logic          v_alloc = 1'b0;
    logic [AW-1:0] v_alloc_addr = '0;

    // Reference model state
    int            m_ptr = 0;
    logic [NR-1:0] m_busy = '0;
    logic          m_wen = 1'b0;
    logic [AW-1:0] m_waddr = '0;
    logic [DW-1:0] m_wdata = '0;
    int            last_k = -1;
    int            grants [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        req_valid_i   = v_valid;
        alloc_valid_i = v_alloc;
        alloc_addr_i  = v_alloc_addr;
        for (int i = 0; i < N; i++) begin
            req_waddr_i[i*AW +: AW] = v_addr[i];
            req_wdata_i[i*DW +: DW] = v_data[i];
        end
    endtask

    // Winner chosen from the arbitration rules: EX first when prioritised, else scan from pointer
    function automatic int pick();
        int c;
        if (PRIO && v_valid[0]) return 0;
        for (int j = 0; j < N; j++) begin
            c = (m_ptr + j) % N;
            if (!(PRIO && c == 0) && v_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_busy = '0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
    endtask

    task automatic tick();
        int k;
        logic [N-1:0]  g;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        apply();
        #1;
        k = pick();
        g = '0;
        if (k >= 0) g = N'(1) << k;
        chk("ready", 64'(req_ready_o), 64'(g));
        last_k = k;
        a = '0; d = '0;
        if (k >= 0) begin
            a = v_addr[k]; d = v_data[k]; grants[k]++;
        end
        for (int r = 1; r < NR; r++) begin
            if (v_alloc && v_alloc_addr == AW'(r)) m_busy[r] = 1'b1;
            else if (k >= 0 && a == AW'(r)) m_busy[r] = 1'b0;
        end
        m_wen = (k >= 0) && (a != '0);
        if (k >= 0) begin
            m_waddr = a; m_wdata = d;
            if (!(PRIO && k == 0)) m_ptr = (k + 1) % N;
        end
        @(posedge clk);
        #1;
        chk("wen",   64'(reg_wen_o),   64'(m_wen));
        chk("waddr", 64'(reg_waddr_o), 64'(m_waddr));
        chk("wdata", 64'(reg_wdata_o), 64'(m_wdata));
        chk("busy",  64'(busy_o),      64'(m_busy));
    endtask

    task automatic idle();
        v_valid = '0; v_alloc = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            v_addr[i] = '0; v_data[i] = '0; grants[i] = 0;
        end

        // Reset state
        #2;
        chk("rst_ready", 64'(req_ready_o), 64'(0));
        chk("rst_wen",   64'(reg_wen_o),   64'(0));
        chk("rst_waddr", 64'(reg_waddr_o), 64'(0));
        chk("rst_wdata", 64'(reg_wdata_o), 64'(0));
        chk("rst_busy",  64'(busy_o),      64'(0));
        @(posedge clk); #1;
        rst = 1'b1;

        // Single EX write
        v_valid = 3'b001; v_addr[0] = 5'd5; v_data[0] = 32'hDEADBEEF;
        tick();
        chk("single_wen",   64'(reg_wen_o),   64'(1));
        chk("single_waddr", 64'(reg_waddr_o), 64'(5));
        chk("single_wdata", 64'(reg_wdata_o), 64'hDEADBEEF);
        idle(); tick();
        chk("single_idle_wen", 64'(reg_wen_o), 64'(0));

        // All three contend continuously
        for (int i = 0; i < N; i++) begin
            v_addr[i] = AW'(i + 1); v_data[i] = 32'hA000_0000 + DW'(i); grants[i] = 0;
        end
        v_valid = 3'b111;
        for (int c = 0; c < 6; c++) tick();
        if (!PRIO) begin
            for (int i = 0; i < N; i++) chk("rr_fair", 64'(grants[i]), 64'(2));
        end else begin
            chk("prio_ex_all", 64'(grants[0]), 64'(6));
        end
        idle(); tick();

        // Reserve x7, retire it from DIV four cycles later
        v_alloc = 1'b1; v_alloc_addr = 5'd7;
        tick();
        v_alloc = 1'b0;
        chk("sb_set7", 64'(busy_o[7]), 64'(1));
        tick(); tick(); tick();
        chk("sb_hold7", 64'(busy_o[7]), 64'(1));
        v_valid = 3'b100; v_addr[REQ_DIV] = 5'd7; v_data[REQ_DIV] = 32'h0000_0777;
        tick();
        chk("sb_clr7", 64'(busy_o[7]), 64'(0));
        idle();

        // Alloc and retire of x9 collide; alloc of x0 ignored
        v_alloc = 1'b1; v_alloc_addr = 5'd9;
        v_valid = 3'b010; v_addr[REQ_LSU] = 5'd9; v_data[REQ_LSU] = 32'h0000_0999;
        tick();
        chk("sb_collide9", 64'(busy_o[9]), 64'(1));
        v_valid = '0; v_alloc_addr = 5'd0;
        tick();
        chk("sb_x0", 64'(busy_o[0]), 64'(0));
        idle();

        // EX write to x0 is consumed silently
        v_valid = 3'b001; v_addr[0] = 5'd0; v_data[0] = 32'h1234_5678;
        tick();
        chk("x0_wen", 64'(reg_wen_o), 64'(0));
        idle();

        // EX and DIV both valid
        v_valid = 3'b101; v_addr[0] = 5'd3; v_addr[2] = 5'd4;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (PRIO) chk("prio_ex_win", 64'(last_k), 64'(0));
        end
        v_valid = 3'b100;
        tick();
        chk("div_after_ex", 64'(last_k), 64'(2));
        idle();

        // Asynchronous reset mid-stream
        v_alloc = 1'b1; v_alloc_addr = 5'd12;
        tick();
        v_alloc = 1'b0;
        v_valid = 3'b111;
        for (int i = 0; i < N; i++) v_addr[i] = AW'(i + 10);
        apply();
        #1; rst = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(req_ready_o), 64'(0));
        chk("mid_rst_wen",   64'(reg_wen_o),   64'(0));
        chk("mid_rst_waddr", 64'(reg_waddr_o), 64'(0));
        chk("mid_rst_wdata", 64'(reg_wdata_o), 64'(0));
        chk("mid_rst_busy",  64'(busy_o),      64'(0));
        rst = 1'b1;
        model_reset();
        tick();
        chk("post_rst_grant", 64'(last_k), 64'(0));

        // Randomised traffic
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!v_valid[i] || last_k == i) begin
                    v_valid[i] = ($urandom_range(0, 99) < 60);
                    v_addr[i]  = AW'($urandom_range(0, 11));
                    v_data[i]  = $urandom;
                end else if ($urandom_range(0, 99) < 10) begin
                    v_valid[i] = 1'b0;
                end
            end
            v_alloc      = ($urandom_range(0, 99) < 30);
            v_alloc_addr = AW'($urandom_range(0, 11));
            tick();
        end
        idle(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
